// File: rtl/operand_stage_if.sv
// operand_stage_if: decoded-instruction, write-back and ALU-operand signals around operand_stage
interface operand_stage_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [15:0]       imm;
  logic              ALUSrc;
  logic [1:0]        ALUOp;
  logic [5:0]        funct;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] entrada1;
  logic [DATA_W-1:0] entrada2;
  logic [3:0]        ALUcontrol;
  logic              out_valid;
  logic              illegal;
  modport master (
    output in_valid, stall, flush, rs, rt, imm, ALUSrc, ALUOp, funct, wb_en, wb_addr, wb_data,
    input  entrada1, entrada2, ALUcontrol, out_valid, illegal
  );
  modport slave (
    input  in_valid, stall, flush, rs, rt, imm, ALUSrc, ALUOp, funct, wb_en, wb_addr, wb_data,
    output entrada1, entrada2, ALUcontrol, out_valid, illegal
  );
endinterface

// File: rtl/operand_stage.sv
// operand_stage: register file read with write-through bypass, operand select and ALU decode into a pipeline register
module operand_stage #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  operand_stage_if.slave  bus
);
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] op_a, op_b, reg_b;
  logic [3:0]        ctl;
  logic              ill;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (bus.wb_en && bus.wb_addr != 5'd0)
      regs[bus.wb_addr] <= bus.wb_data;
  // a write landing on this edge is forwarded so the read sees it in the same cycle
  assign op_a  = (bus.rs == 5'd0) ? '0 :
                 (bus.wb_en && bus.wb_addr == bus.rs) ? bus.wb_data : regs[bus.rs];
  assign reg_b = (bus.rt == 5'd0) ? '0 :
                 (bus.wb_en && bus.wb_addr == bus.rt) ? bus.wb_data : regs[bus.rt];
  assign op_b  = bus.ALUSrc ? {{(DATA_W-16){bus.imm[15]}}, bus.imm} : reg_b;
  always_comb begin
    ctl = 4'b0010;
    ill = 1'b0;
    if (bus.ALUOp == 2'b01) ctl = 4'b0110;
    else if (bus.ALUOp == 2'b11) ill = 1'b1;
    else if (bus.ALUOp == 2'b10)
      case (bus.funct)
        6'b100000: ctl = 4'b0010;
        6'b100010: ctl = 4'b0110;
        6'b100100: ctl = 4'b0000;
        6'b100101: ctl = 4'b0001;
        default:   ill = 1'b1;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n || bus.flush) begin
      bus.out_valid  <= 1'b0;
      bus.entrada1   <= '0;
      bus.entrada2   <= '0;
      bus.ALUcontrol <= 4'b0000;
      bus.illegal    <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid  <= bus.in_valid;
      bus.entrada1   <= op_a;
      bus.entrada2   <= op_b;
      bus.ALUcontrol <= ctl;
      bus.illegal    <= bus.in_valid & ill;
    end
endmodule
